// File: rtl/flash_bus_arbiter_pkg.sv
// Shared definitions for the config-flash bus arbiter: state encoding,
// idle pin levels and the counter width helper. The flash controller and
// loader import the idle levels so their idle-level checks agree with the
// arbiter.
package flash_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic       IDLE_NCE  = 1'b1;
    localparam logic       IDLE_SCLK = 1'b0;
    localparam logic [3:0] IDLE_SOUT = 4'h0;
    localparam logic       IDLE_OE   = 1'b0;

    // Width large enough for both the gap and hold counters, never below 1.
    function automatic int cnt_width(input int gap_cycles, input int max_hold);
        int biggest;
        int w;
        biggest = (gap_cycles > max_hold) ? gap_cycles : max_hold;
        w = $clog2(biggest + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flash_bus_arbiter.sv
// Two-master arbiter for the single SPI/QPI config-flash bus. Round-robin
// grant, enforced nCE-high gap between owners, optional yield request to a
// long-holding owner. The pin mux is combinational from the registered state.
module flash_bus_arbiter
    import flash_bus_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int MAX_HOLD   = 0
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_req,
    input  logic       m1_req,
    output logic       m0_gnt,
    output logic       m1_gnt,
    output logic       m0_yield,
    output logic       m1_yield,

    input  logic       m0_nce,
    input  logic       m0_sclk,
    input  logic [3:0] m0_sout,
    input  logic       m0_oe,
    input  logic       m0_qpi,
    output logic [3:0] m0_sin,

    input  logic       m1_nce,
    input  logic       m1_sclk,
    input  logic [3:0] m1_sout,
    input  logic       m1_oe,
    input  logic       m1_qpi,
    output logic [3:0] m1_sin,

    input  logic [3:0] flash_sin,
    output logic       flash_nce,
    output logic       flash_sclk,
    output logic [3:0] flash_sout,
    output logic       flash_oe,
    output logic       flash_bus_qpi,
    output logic       flash_selected,
    output logic       err_abort
);

    localparam int                CNT_W     = cnt_width(GAP_CYCLES, MAX_HOLD);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_SAT  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]  HOLD_TRIG = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit                YIELD_ON  = (MAX_HOLD > 0);

    arb_state_t       state;
    logic             rr_pref;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             qpi_latched;
    logic             pick_m0;
    logic             pick_m1;

    assign m0_sin = flash_sin;
    assign m1_sin = flash_sin;

    // Round-robin choice among requesters; rr_pref=1 means m1 goes first.
    always_comb begin
        pick_m0 = m0_req && (!m1_req || !rr_pref);
        pick_m1 = m1_req && (!m0_req ||  rr_pref);
    end

    // Arbitration FSM with registered grants, yield, counters and abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_yield    <= 1'b0;
            m1_yield    <= 1'b0;
            err_abort   <= 1'b0;
            rr_pref     <= 1'b0;
            gap_cnt     <= '0;
            hold_cnt    <= '0;
            qpi_latched <= 1'b0;
        end else begin
            err_abort <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (state == ST_GAP && gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else begin
                        gap_cnt  <= '0;
                        hold_cnt <= '0;
                        if (pick_m0) begin
                            state   <= ST_OWN0;
                            m0_gnt  <= 1'b1;
                            rr_pref <= 1'b1;
                        end else if (pick_m1) begin
                            state   <= ST_OWN1;
                            m1_gnt  <= 1'b1;
                            rr_pref <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_OWN0: begin
                    qpi_latched <= m0_qpi;
                    if (!m0_req) begin
                        state     <= ST_GAP;
                        m0_gnt    <= 1'b0;
                        m0_yield  <= 1'b0;
                        hold_cnt  <= '0;
                        gap_cnt   <= '0;
                        err_abort <= !m0_nce;
                    end else if (YIELD_ON && m1_req) begin
                        if (hold_cnt < HOLD_SAT) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        if (hold_cnt >= HOLD_TRIG) begin
                            m0_yield <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                ST_OWN1: begin
                    qpi_latched <= m1_qpi;
                    if (!m1_req) begin
                        state     <= ST_GAP;
                        m1_gnt    <= 1'b0;
                        m1_yield  <= 1'b0;
                        hold_cnt  <= '0;
                        gap_cnt   <= '0;
                        err_abort <= !m1_nce;
                    end else if (YIELD_ON && m0_req) begin
                        if (hold_cnt < HOLD_SAT) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        if (hold_cnt >= HOLD_TRIG) begin
                            m1_yield <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux: the owner drives the bus, otherwise idle levels with the last
    // bus mode held so the flash mode persists between owners.
    always_comb begin
        flash_nce      = IDLE_NCE;
        flash_sclk     = IDLE_SCLK;
        flash_sout     = IDLE_SOUT;
        flash_oe       = IDLE_OE;
        flash_bus_qpi  = qpi_latched;
        flash_selected = 1'b0;
        case (state)
            ST_OWN0: begin
                flash_nce      = m0_nce;
                flash_sclk     = m0_sclk;
                flash_sout     = m0_sout;
                flash_oe       = m0_oe;
                flash_bus_qpi  = m0_qpi;
                flash_selected = 1'b1;
            end
            ST_OWN1: begin
                flash_nce      = m1_nce;
                flash_sclk     = m1_sclk;
                flash_sout     = m1_sout;
                flash_oe       = m1_oe;
                flash_bus_qpi  = m1_qpi;
                flash_selected = 1'b1;
            end
            default: begin
                flash_selected = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: main instance with MAX_HOLD=8 and a
// shadow instance with MAX_HOLD=0 driven by the same inputs.
module tb_flash_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m1_req;
    logic       m0_nce, m0_sclk, m0_oe, m0_qpi;
    logic       m1_nce, m1_sclk, m1_oe, m1_qpi;
    logic [3:0] m0_sout, m1_sout, flash_sin;

    logic       m0_gnt, m1_gnt, m0_yield, m1_yield;
    logic [3:0] m0_sin, m1_sin;
    logic       flash_nce, flash_sclk, flash_oe, flash_bus_qpi, flash_selected, err_abort;
    logic [3:0] flash_sout;

    logic       nh_m0_gnt, nh_m1_gnt, nh_m0_yield, nh_m1_yield;
    logic [3:0] nh_m0_sin, nh_m1_sin, nh_flash_sout;
    logic       nh_flash_nce, nh_flash_sclk, nh_flash_oe, nh_flash_bus_qpi;
    logic       nh_flash_selected, nh_err_abort;

    int checks = 0;
    int errors = 0;

    flash_bus_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_yield(m0_yield), .m1_yield(m1_yield),
        .m0_nce(m0_nce), .m0_sclk(m0_sclk), .m0_sout(m0_sout), .m0_oe(m0_oe),
        .m0_qpi(m0_qpi), .m0_sin(m0_sin),
        .m1_nce(m1_nce), .m1_sclk(m1_sclk), .m1_sout(m1_sout), .m1_oe(m1_oe),
        .m1_qpi(m1_qpi), .m1_sin(m1_sin),
        .flash_sin(flash_sin), .flash_nce(flash_nce), .flash_sclk(flash_sclk),
        .flash_sout(flash_sout), .flash_oe(flash_oe), .flash_bus_qpi(flash_bus_qpi),
        .flash_selected(flash_selected), .err_abort(err_abort)
    );

    flash_bus_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(0)) dut_nh (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_gnt(nh_m0_gnt), .m1_gnt(nh_m1_gnt),
        .m0_yield(nh_m0_yield), .m1_yield(nh_m1_yield),
        .m0_nce(m0_nce), .m0_sclk(m0_sclk), .m0_sout(m0_sout), .m0_oe(m0_oe),
        .m0_qpi(m0_qpi), .m0_sin(nh_m0_sin),
        .m1_nce(m1_nce), .m1_sclk(m1_sclk), .m1_sout(m1_sout), .m1_oe(m1_oe),
        .m1_qpi(m1_qpi), .m1_sin(nh_m1_sin),
        .flash_sin(flash_sin), .flash_nce(nh_flash_nce), .flash_sclk(nh_flash_sclk),
        .flash_sout(nh_flash_sout), .flash_oe(nh_flash_oe), .flash_bus_qpi(nh_flash_bus_qpi),
        .flash_selected(nh_flash_selected), .err_abort(nh_err_abort)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Sets every master input to its quiet level.
    task automatic applyStimulus();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_nce = 1'b1; m0_sclk = 1'b0; m0_sout = 4'h0; m0_oe = 1'b0; m0_qpi = 1'b0;
        m1_nce = 1'b1; m1_sclk = 1'b0; m1_sout = 4'h0; m1_oe = 1'b0; m1_qpi = 1'b0;
        flash_sin = 4'h6;
    endtask

    // Directed scenario sequence.
    initial begin
        applyStimulus();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        checkOutput("rst_m0_gnt", m0_gnt, 1'b0);
        checkOutput("rst_m1_gnt", m1_gnt, 1'b0);
        checkOutput("rst_nce", flash_nce, 1'b1);
        checkOutput("rst_sel", flash_selected, 1'b0);
        checkOutput("rst_qpi", flash_bus_qpi, 1'b0);
        checkOutput("rst_err", err_abort, 1'b0);
        checkOutput("sin_fanout", {m0_sin, m1_sin}, 8'h66);

        // m0 alone: grant one cycle after request, pins follow m0
        m0_req = 1'b1;
        step();
        checkOutput("own0_gnt", m0_gnt, 1'b1);
        checkOutput("own0_m1_gnt", m1_gnt, 1'b0);
        checkOutput("own0_sel", flash_selected, 1'b1);
        checkOutput("own0_nce_hi", flash_nce, 1'b1);
        m0_nce = 1'b0; m0_sclk = 1'b1; m0_sout = 4'hA; m0_oe = 1'b1;
        m1_nce = 1'b0; m1_sout = 4'h5;
        #1;
        checkOutput("own0_nce_lo", flash_nce, 1'b0);
        checkOutput("own0_pins", {flash_sclk, flash_oe, flash_sout}, 6'h3A);

        // clean release, m1 requests during the gap
        m0_nce = 1'b1; m0_sclk = 1'b0; m0_sout = 4'h0; m0_oe = 1'b0; m0_req = 1'b0;
        step();
        checkOutput("rel_m0_gnt", m0_gnt, 1'b0);
        checkOutput("rel_err", err_abort, 1'b0);
        checkOutput("gap1_nce", flash_nce, 1'b1);
        checkOutput("gap1_sel", flash_selected, 1'b0);
        m1_req = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            step();
            checkOutput($sformatf("gap%0d_m1_gnt", i), m1_gnt, 1'b0);
            checkOutput($sformatf("gap%0d_nce", i), flash_nce, 1'b1);
        end
        step();
        checkOutput("gap_end_m1_gnt", m1_gnt, 1'b1);
        checkOutput("own1_nce", flash_nce, 1'b0);
        checkOutput("own1_sout", flash_sout, 4'h5);

        // m1 releases with nCE still low: single abort pulse
        m1_req = 1'b0;
        step();
        checkOutput("abort_gnt", m1_gnt, 1'b0);
        checkOutput("abort_pulse", err_abort, 1'b1);
        checkOutput("abort_nce", flash_nce, 1'b1);
        step();
        checkOutput("abort_once", err_abort, 1'b0);
        m1_nce = 1'b1; m1_sout = 4'h0;
        step();
        step();
        step();
        // idle now: a fresh request is granted on the next edge
        m0_req = 1'b1;
        step();
        checkOutput("idle_regrant", m0_gnt, 1'b1);

        // reset while m0 is mid-transaction in QPI mode
        m0_nce = 1'b0; m0_sclk = 1'b1; m0_qpi = 1'b1;
        #1;
        checkOutput("pre_rst_qpi", flash_bus_qpi, 1'b1);
        rst = 1'b1; m1_req = 1'b1;
        step();
        checkOutput("midrst_gnt", {m0_gnt, m1_gnt}, 2'b00);
        checkOutput("midrst_pins", {flash_nce, flash_sclk, flash_selected, flash_bus_qpi}, 4'b1000);
        rst = 1'b0; m0_nce = 1'b1; m0_sclk = 1'b0; m0_qpi = 1'b0;

        // both request after reset: m0 wins, yield after 8 contended cycles
        step();
        checkOutput("both_m0_gnt", m0_gnt, 1'b1);
        checkOutput("both_m1_gnt", m1_gnt, 1'b0);
        for (int i = 2; i <= 8; i++) step();
        checkOutput("hold8_yield", m0_yield, 1'b0);
        step();
        checkOutput("hold9_yield", m0_yield, 1'b1);
        checkOutput("nh_yield", nh_m0_yield, 1'b0);
        step(); step(); step();
        checkOutput("yield_sticky", m0_yield, 1'b1);
        checkOutput("no_preempt", {m0_gnt, m1_gnt}, 2'b10);
        checkOutput("nh_no_preempt", {nh_m0_gnt, nh_m1_gnt}, 2'b10);

        // QPI mode persists through the gap until m1 drives it
        m0_qpi = 1'b1;
        #1;
        checkOutput("own0_qpi", flash_bus_qpi, 1'b1);
        m0_req = 1'b0;
        step();
        checkOutput("rel_yield", m0_yield, 1'b0);
        checkOutput("rel_gnt2", m0_gnt, 1'b0);
        m0_qpi = 1'b0;
        #1;
        checkOutput("gap_qpi_held", flash_bus_qpi, 1'b1);
        step(); step(); step();
        checkOutput("gap4_qpi_held", flash_bus_qpi, 1'b1);
        checkOutput("gap4_m1_gnt", m1_gnt, 1'b0);
        step();
        checkOutput("after_gap_m1", m1_gnt, 1'b1);
        checkOutput("m1_qpi0", flash_bus_qpi, 1'b0);

        // m1 releases and re-requests in the gap; pending m0 wins
        m1_req = 1'b0;
        step();
        m1_req = 1'b1;
        step();
        m0_req = 1'b1;
        step(); step();
        checkOutput("rr_gap4", {m0_gnt, m1_gnt}, 2'b00);
        step();
        checkOutput("rr_winner", {m0_gnt, m1_gnt}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
